// File: rtl/upp_tx_frame_ctrl.sv
// upp_tx_frame_ctrl: drains one of CH_NUM source FIFOs onto the uPP bus in
// fixed PKT_LEN-word packets (back-to-back when enough data is queued, zero-
// padded tail at end of frame), then runs the GPIO_5/GPIO_0 DSP handshake.
// Optional feature macro: UPP_TX_TIMEOUT_EN (handoff timeout -> oTIMEOUT).
module upp_tx_frame_ctrl #(
  parameter int DATA_W         = 16,
  parameter int USEDW_W        = 9,
  parameter int CH_NUM         = 2,
  parameter int PKT_LEN        = 256,
  parameter int USEDW_THR      = 256,
  parameter int FIFO_LAT       = 1,
  parameter int CHECK_GPIO5    = 100,
  parameter int BETWEEN_FRAMES = 100,
  parameter int TIMEOUT        = 65535,
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic                       iSTART,
  input  logic                       iGPIO5,
  input  logic [CH_W-1:0]            iCH_SEL,
  input  logic [CH_NUM-1:0]          iEMPTY,
  input  logic [CH_NUM*USEDW_W-1:0]  iUSEDW,
  input  logic [CH_NUM*DATA_W-1:0]   iFIFO_OUT,
  output logic [CH_NUM-1:0]          oRD_REQ,
  output logic [DATA_W-1:0]          oDATA_UPP,
  output logic                       oENA,
  output logic                       oGPIO_0,
  output logic [CH_W-1:0]            oSEL_CHANNEL,
  output logic                       oBUSY,
  output logic                       oFRAME_DONE,
  output logic                       oTIMEOUT
);

  localparam int SC_W  = $clog2(PKT_LEN + 1);
  localparam int HS_W  = (CHECK_GPIO5 > 0) ? $clog2(CHECK_GPIO5 + 1) : 1;
  localparam int GAP_W = (BETWEEN_FRAMES > 0) ? $clog2(BETWEEN_FRAMES + 1) : 1;
  // Registered usedw lags the FIFO by the previous and the current read.
  localparam int INFLIGHT = 2;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_HANDOFF, S_GAP} state_t;

  state_t                      state_q, state_d;
  logic                        start_q, start_d, start_clr;
  logic [CH_NUM*USEDW_W-1:0]   usedw_q;
  logic [CH_W-1:0]             sel_q, sel_d;
  logic [SC_W-1:0]             slot_cnt_q, slot_cnt_d, n_q, n_d;
  logic                        full_q, full_d;
  logic [FIFO_LAT-1:0]         slot_pipe_q, slot_pipe_d, rd_pipe_q, rd_pipe_d;
  logic                        ena_q, ena_d;
  logic [DATA_W-1:0]           data_q, data_d;
  logic [HS_W-1:0]             hs_cnt_q, hs_cnt_d;
  logic [GAP_W-1:0]            gap_cnt_q, gap_cnt_d;
  logic                        frame_done_q, frame_done_d;
  logic                        hs_word, rd_req, issue;
  logic [USEDW_W-1:0]          usedw_sel;
  logic [DATA_W-1:0]           fifo_sel;
  logic                        empty_sel;
`ifdef UPP_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
  logic                        timeout_q, timeout_d;
`endif

  // Select the active channel's registered usedw, FIFO data and empty flag
  always_comb begin
    usedw_sel = '0;
    fifo_sel  = '0;
    empty_sel = 1'b0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (sel_q == CH_W'(k)) begin
        usedw_sel = usedw_q[k*USEDW_W +: USEDW_W];
        fifo_sel  = iFIFO_OUT[k*DATA_W +: DATA_W];
        empty_sel = iEMPTY[k];
      end
    end
  end

  // Slot issue: every packet has PKT_LEN slots, the first n_q of them read
  always_comb begin
    issue  = (state_q == S_READ) && (slot_cnt_q < SC_W'(PKT_LEN));
    rd_req = issue && (slot_cnt_q < n_q);
    oRD_REQ = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      oRD_REQ[k] = rd_req && (sel_q == CH_W'(k));
    end
    slot_pipe_d[0] = issue;
    rd_pipe_d[0]   = rd_req;
    for (int unsigned i = 1; i < FIFO_LAT; i++) begin
      slot_pipe_d[i] = slot_pipe_q[i-1];
      rd_pipe_d[i]   = rd_pipe_q[i-1];
    end
  end

  // Next-state, counters and handshake decisions
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    slot_cnt_d   = slot_cnt_q;
    n_d          = n_q;
    full_d       = full_q;
    hs_cnt_d     = '0;
    gap_cnt_d    = '0;
    frame_done_d = 1'b0;
    hs_word      = 1'b0;
    start_clr    = 1'b0;
`ifdef UPP_TX_TIMEOUT_EN
    to_cnt_d     = '0;
    timeout_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (iGPIO5) begin
          sel_d   = (int'(iCH_SEL) >= CH_NUM) ? '0 : iCH_SEL;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        slot_cnt_d = '0;
        if (32'(usedw_sel) >= USEDW_THR) begin
          n_d     = SC_W'(PKT_LEN);
          full_d  = 1'b1;
          state_d = S_READ;
        end else if (start_q && !empty_sel) begin
          n_d     = (32'(usedw_sel) >= PKT_LEN) ? SC_W'(PKT_LEN) : SC_W'(usedw_sel);
          full_d  = 1'b0;
          state_d = S_READ;
        end else if (start_q) begin
          state_d = S_HANDOFF;
        end
      end
      S_READ: begin
        if (issue) begin
          slot_cnt_d = slot_cnt_q + 1'b1;
          // Restarting the slot counter on the last read keeps oENA gapless
          if ((slot_cnt_q == SC_W'(PKT_LEN - 1)) && full_q &&
              (32'(usedw_sel) >= USEDW_THR + INFLIGHT)) begin
            slot_cnt_d = '0;
          end
        end else if ((slot_pipe_q == '0) && ena_q) begin
          state_d = S_CHECK;
        end
      end
      S_HANDOFF: begin
        if (!iGPIO5) begin
          state_d = S_GAP;
        end else begin
          if (hs_cnt_q == HS_W'(CHECK_GPIO5)) hs_word = 1'b1;
          else hs_cnt_d = hs_cnt_q + 1'b1;
`ifdef UPP_TX_TIMEOUT_EN
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = S_GAP;
          end
`endif
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(BETWEEN_FRAMES - 1)) begin
          state_d      = S_IDLE;
          start_clr    = 1'b1;
          frame_done_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    start_d = iSTART | (start_q & ~start_clr);
    ena_d   = slot_pipe_q[FIFO_LAT-1] | hs_word;
    data_d  = rd_pipe_q[FIFO_LAT-1] ? fifo_sel : '0;
  end

  // State and datapath registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      usedw_q      <= '0;
      sel_q        <= '0;
      slot_cnt_q   <= '0;
      n_q          <= '0;
      full_q       <= 1'b0;
      slot_pipe_q  <= '0;
      rd_pipe_q    <= '0;
      ena_q        <= 1'b0;
      data_q       <= '0;
      hs_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      usedw_q      <= iUSEDW;
      sel_q        <= sel_d;
      slot_cnt_q   <= slot_cnt_d;
      n_q          <= n_d;
      full_q       <= full_d;
      slot_pipe_q  <= slot_pipe_d;
      rd_pipe_q    <= rd_pipe_d;
      ena_q        <= ena_d;
      data_q       <= data_d;
      hs_cnt_q     <= hs_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef UPP_TX_TIMEOUT_EN
  // Handoff timeout counter and pulse
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign oTIMEOUT = timeout_q;
`else
  assign oTIMEOUT = 1'b0;
`endif

  assign oDATA_UPP    = data_q;
  assign oENA         = ena_q;
  assign oGPIO_0      = (state_q == S_HANDOFF);
  assign oSEL_CHANNEL = sel_q;
  assign oBUSY        = (state_q != S_IDLE);
  assign oFRAME_DONE  = frame_done_q;

endmodule

// File: tb/tb_upp_tx_frame_ctrl.sv
// Directed bench for upp_tx_frame_ctrl with a behavioural two-channel FIFO.
module tb_upp_tx_frame_ctrl;

  logic        clk = 1'b0;
  logic        iRST_N, iSTART, iGPIO5;
  logic [0:0]  iCH_SEL;
  logic [1:0]  iEMPTY;
  logic [19:0] iUSEDW;
  logic [31:0] iFIFO_OUT;
  logic [1:0]  oRD_REQ;
  logic [15:0] oDATA_UPP;
  logic        oENA, oGPIO_0, oBUSY, oFRAME_DONE, oTIMEOUT;
  logic [0:0]  oSEL_CHANNEL;

  always #5 clk = ~clk;

  upp_tx_frame_ctrl #(.USEDW_W(10), .TIMEOUT(50)) dut (
    .iCLK(clk), .iRST_N(iRST_N), .iSTART(iSTART), .iGPIO5(iGPIO5),
    .iCH_SEL(iCH_SEL), .iEMPTY(iEMPTY), .iUSEDW(iUSEDW), .iFIFO_OUT(iFIFO_OUT),
    .oRD_REQ(oRD_REQ), .oDATA_UPP(oDATA_UPP), .oENA(oENA), .oGPIO_0(oGPIO_0),
    .oSEL_CHANNEL(oSEL_CHANNEL), .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE),
    .oTIMEOUT(oTIMEOUT)
  );

  function automatic logic [15:0] pat(input int ch, input int i);
    return 16'((ch + 1) * 4096 + (i % 4096));
  endfunction

  // FIFO model: show-ahead-free, one-cycle read latency, usedw updates after a read
  int          cnt [2];
  int          rp  [2];
  logic [15:0] q   [2];
  logic [1:0]  fill_go;
  int          fill_n [2];
  int          cyc;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (fill_go[k]) begin
        cnt[k] <= fill_n[k];
        rp[k]  <= 0;
      end else if (oRD_REQ[k] && cnt[k] > 0) begin
        cnt[k] <= cnt[k] - 1;
        rp[k]  <= rp[k] + 1;
        q[k]   <= pat(k, rp[k]);
      end
    end
  end

  always_comb begin
    iUSEDW    = {10'(cnt[1]), 10'(cnt[0])};
    iFIFO_OUT = {q[1], q[0]};
    iEMPTY    = {cnt[1] == 0, cnt[0] == 0};
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int rd0, rd1, ena_n, run, max_run, rd_run, max_rd_run, first_rd, first_ena, last_ena;
  int zviol, g0_n, tmo_n;
  logic [15:0] got_data [$];

  task automatic clr_stats();
    rd0 = 0; rd1 = 0; ena_n = 0; run = 0; max_run = 0; rd_run = 0; max_rd_run = 0;
    first_rd = -1; first_ena = -1; last_ena = -1; zviol = 0; g0_n = 0; tmo_n = 0;
    got_data.delete();
  endtask

  task automatic sample();
    if (oRD_REQ[0]) rd0++;
    if (oRD_REQ[1]) rd1++;
    if (oRD_REQ != 2'b00) begin
      if (first_rd < 0) first_rd = cyc;
      rd_run++;
      if (rd_run > max_rd_run) max_rd_run = rd_run;
    end else rd_run = 0;
    if (oENA) begin
      if (first_ena < 0) first_ena = cyc;
      last_ena = cyc;
      ena_n++;
      run++;
      if (run > max_run) max_run = run;
      got_data.push_back(oDATA_UPP);
    end else begin
      run = 0;
      if (oDATA_UPP != 16'h0) zviol++;
    end
    if (oGPIO_0) g0_n++;
    if (oTIMEOUT) tmo_n++;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
  endtask

  task automatic fill(input int ch, input int n);
    fill_n[ch] = n;
    fill_go[ch] = 1'b1;
    @(negedge clk);
    fill_go[ch] = 1'b0;
  endtask

  task automatic do_reset();
    iGPIO5 = 1'b0; iSTART = 1'b0;
    iRST_N = 1'b0;
    fill(0, 0);
    fill(1, 0);
    @(negedge clk);
    iRST_N = 1'b1;
    @(negedge clk);
  endtask

  int k, j, dmis;

  initial begin
    cyc = 0; fill_go = 2'b00; fill_n[0] = 0; fill_n[1] = 0;
    cnt[0] = 0; cnt[1] = 0; rp[0] = 0; rp[1] = 0; q[0] = '0; q[1] = '0;
    iRST_N = 1'b0; iSTART = 1'b0; iGPIO5 = 1'b0; iCH_SEL = 1'b0;
    clr_stats();

    // Reset state
    @(negedge clk);
    chk("rst_outputs", {oRD_REQ, oDATA_UPP, oENA, oGPIO_0, oSEL_CHANNEL, oBUSY, oFRAME_DONE, oTIMEOUT}, 0);
    do_reset();
    chk("rst_busy", oBUSY, 0);

    // T1: one full packet from channel 0
    fill(0, 256);
    clr_stats();
    iCH_SEL = 1'b0; iGPIO5 = 1'b1;
    for (int i = 0; i < 300; i++) step();
    chk("t1_rd0", rd0, 256);
    chk("t1_rd1", rd1, 0);
    chk("t1_rd_run", max_rd_run, 256);
    chk("t1_ena", ena_n, 256);
    chk("t1_ena_run", max_run, 256);
    chk("t1_ena_latency", first_ena - first_rd, 2);
    dmis = 0;
    for (int i = 0; i < got_data.size(); i++) if (got_data[i] != pat(0, i)) dmis++;
    chk("t1_data", dmis, 0);
    chk("t1_zero_idle", zviol, 0);
    chk("t1_busy_check", oBUSY, 1);
    chk("t1_gpio0", g0_n, 0);

    // T2: 600 words on channel 1 -> two back-to-back packets
    do_reset();
    fill(1, 600);
    clr_stats();
    iCH_SEL = 1'b1; iGPIO5 = 1'b1;
    for (int i = 0; i < 700; i++) step();
    chk("t2_rd1", rd1, 512);
    chk("t2_rd0", rd0, 0);
    chk("t2_rd_run", max_rd_run, 512);
    chk("t2_ena", ena_n, 512);
    chk("t2_ena_run", max_run, 512);
    chk("t2_sel", oSEL_CHANNEL, 1);
    dmis = 0;
    for (int i = 0; i < got_data.size(); i++) if (got_data[i] != pat(1, i)) dmis++;
    chk("t2_data", dmis, 0);
    chk("t2_left", cnt[1], 88);

    // T3: 100-word tail packet, then handoff
    do_reset();
    fill(0, 100);
    iCH_SEL = 1'b0;
    iSTART = 1'b1; @(negedge clk); iSTART = 1'b0;
    clr_stats();
    iGPIO5 = 1'b1;
    k = 0;
    while (!oGPIO_0 && k < 400) begin step(); k++; end
    chk("t3_handoff_reached", oGPIO_0, 1);
    chk("t3_rd0", rd0, 100);
    chk("t3_ena", ena_n, 256);
    chk("t3_ena_run", max_run, 256);
    dmis = 0;
    for (int i = 0; i < got_data.size(); i++)
      if (got_data[i] != ((i < 100) ? pat(0, i) : 16'h0)) dmis++;
    chk("t3_tail_data", dmis, 0);
    clr_stats();
    j = cyc;
`ifdef UPP_TX_TIMEOUT_EN
    k = 0;
    while (!oTIMEOUT && k < 200) begin step(); k++; end
    chk("t3_timeout_delay", k, 50);
    chk("t3_timeout_gap_gpio0", oGPIO_0, 0);
    step();
    chk("t3_timeout_pulse", oTIMEOUT, 0);
    k = 1;
    while (!oFRAME_DONE && k < 300) begin step(); k++; end
    chk("t3_gap_len", k, 100);
`else
    for (int i = 0; i < 300; i++) step();
    chk("t3_stim_words", ena_n, 2);
    chk("t3_stim_first", first_ena - j, 101);
    chk("t3_stim_period", last_ena - first_ena, 101);
    dmis = 0;
    for (int i = 0; i < got_data.size(); i++) if (got_data[i] != 16'h0) dmis++;
    chk("t3_stim_zero", dmis, 0);
    chk("t3_still_handoff", oGPIO_0, 1);
    chk("t3_no_timeout", tmo_n, 0);
    iGPIO5 = 1'b0;
    clr_stats();
    k = 0;
    while (!oFRAME_DONE && k < 300) begin step(); k++; end
    chk("t3_gap_len", k, 101);
    chk("t3_gap_gpio0", g0_n, 0);
    chk("t3_gap_ena", ena_n, 0);
`endif
    chk("t3_done_idle", oBUSY, 0);
    step();
    chk("t3_done_pulse", oFRAME_DONE, 0);
    // Latch was cleared: empty FIFO must not lead back to HANDOFF
    iGPIO5 = 1'b1;
    clr_stats();
    for (int i = 0; i < 30; i++) step();
    chk("t3_latch_cleared", g0_n, 0);

    // T4: asynchronous reset in the middle of a packet
    do_reset();
    fill(0, 256);
    clr_stats();
    iGPIO5 = 1'b1;
    k = 0;
    while (ena_n < 37 && k < 400) begin step(); k++; end
    chk("t4_mid_ena", oENA, 1);
    #2 iRST_N = 1'b0;
    #1;
    chk("t4_async_outs", {oRD_REQ, oDATA_UPP, oENA, oGPIO_0}, 0);
    chk("t4_async_busy", oBUSY, 0);
    iGPIO5 = 1'b0;
    @(negedge clk);
    iRST_N = 1'b1;
    clr_stats();
    for (int i = 0; i < 20; i++) step();
    chk("t4_idle_busy", oBUSY, 0);
    chk("t4_no_completion", ena_n + rd0, 0);

    // T5: iSTART coincides with the GAP-exit latch clear
    do_reset();
    iSTART = 1'b1; @(negedge clk); iSTART = 1'b0;
    iGPIO5 = 1'b1;
    k = 0;
    while (!oGPIO_0 && k < 20) begin step(); k++; end
    chk("t5_handoff", oGPIO_0, 1);
    iGPIO5 = 1'b0;
    for (int i = 0; i < 100; i++) step();
    iSTART = 1'b1;
    step();
    iSTART = 1'b0;
    chk("t5_frame_done", oFRAME_DONE, 1);
    for (int i = 0; i < 3; i++) step();
    iGPIO5 = 1'b1;
    k = 0;
    while (!oGPIO_0 && k < 10) begin step(); k++; end
    chk("t5_latch_kept", k, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
